// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - configurable SPI master with chip-select hold between words
module spi_master_cfg #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1,
  parameter int NUM_CS    = 1,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold_cs,
  input  logic              release_cs,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic [NUM_CS-1:0] CS_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EC_W  = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EC_W-1:0]  EDGE_LAST = EC_W'(2 * DATA_W);
  localparam logic SCK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, HOLD, TRAIL} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [EC_W-1:0]   edge_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic              hold_q;
  logic [NUM_CS-1:0] cs_dec;
  logic              accept, tick, xfer_done, sck_edge, odd_edge, last_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign accept    = tx_valid && tx_ready;
  assign tick      = (div_cnt == DIV_LAST);
  assign xfer_done = (state == XFER) && (edge_cnt == EDGE_LAST);
  // The lead-in tick produces edge 1; XFER ticks produce the remaining edges.
  assign sck_edge  = ((state == LEAD) && tick) || ((state == XFER) && tick && !xfer_done);
  assign odd_edge  = !edge_cnt[0];
  assign last_edge = (edge_cnt == EDGE_LAST - 1'b1);
  assign busy      = (state != IDLE);

  // Decode the requested slave; an out-of-range index selects nobody.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
    end
  end

  // Next-state selection; a new word in HOLD wins over release.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LEAD;
      LEAD:    if (tick) state_nxt = XFER;
      XFER:    if (xfer_done) state_nxt = hold_q ? HOLD : TRAIL;
      HOLD: begin
        if (accept) state_nxt = XFER;
        else if (release_cs) state_nxt = TRAIL;
      end
      TRAIL:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Half-period divider, restarted on every state change so phases are exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               div_cnt <= '0;
    else if ((state_nxt != state) || tick) div_cnt <= '0;
    else                                   div_cnt <= div_cnt + 1'b1;
  end

  // SCK generation plus MOSI shift / MISO sample on the phase-selected edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SCK      <= SCK_IDLE;
      MOSI     <= 1'b1;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else if (accept) begin
      edge_cnt <= '0;
      if (CPHA == 0) begin
        MOSI  <= first_bit(tx_data);
        tx_sh <= shifted(tx_data);
      end else begin
        tx_sh <= tx_data;
      end
    end else if (sck_edge) begin
      SCK      <= ~SCK;
      edge_cnt <= edge_cnt + 1'b1;
      if (odd_edge == (CPHA == 0)) begin
        rx_sh <= (MSB_FIRST != 0) ? {rx_sh[DATA_W-2:0], MISO} : {MISO, rx_sh[DATA_W-1:1]};
      end else if (!last_edge) begin
        MOSI  <= first_bit(tx_sh);
        tx_sh <= shifted(tx_sh);
      end
    end else if (xfer_done) begin
      MOSI     <= 1'b1;
      edge_cnt <= '0;
    end
  end

  // Handshake, chip selects and received-word delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      hold_q   <= 1'b0;
      CS_n     <= '1;
    end else begin
      tx_ready <= (state_nxt == IDLE) || (state_nxt == HOLD);
      rx_valid <= xfer_done;
      if (xfer_done) rx_data <= rx_sh;
      if (accept) hold_q <= hold_cs;
      if ((state == IDLE) && accept) CS_n <= cs_dec;
      else if ((state == TRAIL) && tick) CS_n <= '1;
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - directed bench for spi_master_cfg
module tb_spi_master_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       hold_cs = 1'b0;
  logic       release_cs = 1'b0;
  logic [3:0] tv = '0;
  logic       cs0 = 1'b0;
  logic [1:0] cs3 = '0;

  logic [3:0] rdy, rxv, bsy, mosi, sck;
  logic [7:0] rxd [4];
  logic       miso0, miso1, miso2, miso3;
  logic       cs_n0, cs_n1, cs_n2;
  logic [2:0] cs_n3;

  int         slv_cnt = 0;
  logic [7:0] slv_pat = 8'h3C;

  always #5 clk = ~clk;

  assign miso0 = mosi[0];
  assign miso2 = mosi[2];
  assign miso3 = mosi[3];

  // Mode-3 slave: presents the next bit of its word on each leading (falling) edge.
  always @(negedge sck[1]) slv_cnt <= slv_cnt + 1;
  assign miso1 = (slv_cnt >= 1 && slv_cnt <= 8) ? slv_pat[8 - slv_cnt] : 1'b0;

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .NUM_CS(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tv[0]), .tx_ready(rdy[0]), .tx_data(tx_data), .cs_sel(cs0),
    .hold_cs(hold_cs), .release_cs(release_cs), .rx_valid(rxv[0]), .rx_data(rxd[0]), .busy(bsy[0]),
    .MISO(miso0), .MOSI(mosi[0]), .SCK(sck[0]), .CS_n(cs_n0));

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .NUM_CS(1)) u1 (
    .clk(clk), .rst(rst), .tx_valid(tv[1]), .tx_ready(rdy[1]), .tx_data(tx_data), .cs_sel(cs0),
    .hold_cs(hold_cs), .release_cs(release_cs), .rx_valid(rxv[1]), .rx_data(rxd[1]), .busy(bsy[1]),
    .MISO(miso1), .MOSI(mosi[1]), .SCK(sck[1]), .CS_n(cs_n1));

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .NUM_CS(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(tv[2]), .tx_ready(rdy[2]), .tx_data(tx_data), .cs_sel(cs0),
    .hold_cs(hold_cs), .release_cs(release_cs), .rx_valid(rxv[2]), .rx_data(rxd[2]), .busy(bsy[2]),
    .MISO(miso2), .MOSI(mosi[2]), .SCK(sck[2]), .CS_n(cs_n2));

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .NUM_CS(3)) u3 (
    .clk(clk), .rst(rst), .tx_valid(tv[3]), .tx_ready(rdy[3]), .tx_data(tx_data), .cs_sel(cs3),
    .hold_cs(hold_cs), .release_cs(release_cs), .rx_valid(rxv[3]), .rx_data(rxd[3]), .busy(bsy[3]),
    .MISO(miso3), .MOSI(mosi[3]), .SCK(sck[3]), .CS_n(cs_n3));

  int n_cmp = 0;
  int n_fail = 0;

  int         off1, off2, rel_a, rel_b, rst_on, rst_off;
  logic [7:0] d1, d2;
  logic       h1, h2;
  logic [1:0] csg;

  logic       tr_sck [100];
  logic       tr_mosi [100];
  logic       tr_rxv [100];
  logic       tr_rdy [100];
  logic       tr_busy [100];
  logic [2:0] tr_cs [100];
  logic [7:0] tr_rxd [100];
  logic       sn_sck, sn_mosi, sn_rxv, sn_rdy, sn_busy, sn_cs;
  logic [7:0] sn_rxd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [7:0] d, input logic h);
    off1 = 0; off2 = -1; rel_a = -1; rel_b = -1; rst_on = 1000; rst_off = 0;
    d1 = d; h1 = h; d2 = '0; h2 = 1'b0; csg = '0;
  endtask

  // Cycle n of a run is the n-th cycle after the start; a word offered at n is accepted at the end of n.
  task automatic run(input int idx, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      tr_sck[n]  = sck[idx];
      tr_mosi[n] = mosi[idx];
      tr_rxv[n]  = rxv[idx];
      tr_rdy[n]  = rdy[idx];
      tr_busy[n] = bsy[idx];
      tr_rxd[n]  = rxd[idx];
      case (idx)
        0: tr_cs[n] = {2'b11, cs_n0};
        1: tr_cs[n] = {2'b11, cs_n1};
        2: tr_cs[n] = {2'b11, cs_n2};
        default: tr_cs[n] = cs_n3;
      endcase
      tv = '0;
      if (n == off1 || n == off2) tv[idx] = 1'b1;
      tx_data    = (n == off2) ? d2 : d1;
      hold_cs    = (n == off2) ? h2 : h1;
      cs3        = csg;
      release_cs = (n == rel_a || n == rel_b);
      rst        = (n >= rst_on && n < rst_off);
      if (n == rst_on) begin
        #1;
        sn_sck = sck[idx]; sn_mosi = mosi[idx]; sn_rxv = rxv[idx];
        sn_rdy = rdy[idx]; sn_busy = bsy[idx]; sn_cs = cs_n0; sn_rxd = rxd[idx];
      end
    end
    tv = '0;
    release_cs = 1'b0;
    hold_cs = 1'b0;
  endtask

  task automatic chk_basic_a5();
    int rises, pulses, pcyc;
    rises = 0; pulses = 0; pcyc = -1;
    for (int n = 1; n < 40; n++) begin
      if (tr_sck[n] && !tr_sck[n-1]) begin
        chk("a5_rise_cycle", n, 3 + 4 * rises);
        rises++;
      end
      if (tr_rxv[n]) begin pulses++; pcyc = n; end
    end
    chk("a5_rise_count", rises, 8);
    chk("a5_rxv_count", pulses, 1);
    chk("a5_rxv_cycle", pcyc, 34);
    chk("a5_rx_data", tr_rxd[35], 8'hA5);
    chk("a5_cs_t0", tr_cs[0][0], 1'b1);
    chk("a5_cs_t1", tr_cs[1][0], 1'b0);
    chk("a5_cs_t35", tr_cs[35][0], 1'b0);
    chk("a5_cs_t36", tr_cs[36][0], 1'b1);
    chk("a5_ready_t35", tr_rdy[35], 1'b0);
    chk("a5_ready_t36", tr_rdy[36], 1'b1);
    chk("a5_busy_t1", tr_busy[1], 1'b1);
  endtask

  initial begin
    int cnt, cnt2, c1, c2;

    repeat (2) @(negedge clk);
    chk("rst_cs_n", cs_n0, 1'b1);
    chk("rst_cs_n3", cs_n3, 3'b111);
    chk("rst_sck_cpol0", sck[0], 1'b0);
    chk("rst_sck_cpol1", sck[1], 1'b1);
    chk("rst_mosi", mosi[0], 1'b1);
    chk("rst_ready", rdy[0], 1'b1);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_rx_valid", rxv[0], 1'b0);
    chk("rst_rx_data", rxd[0], 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0 loopback, 0xA5.
    setup(8'hA5, 1'b0);
    run(0, 40);
    chk_basic_a5();

    // Mode 3 against a slave returning 0x3C.
    setup(8'hFF, 1'b0);
    run(1, 40);
    cnt = 0; cnt2 = 0; c1 = -1;
    for (int n = 1; n < 40; n++) begin
      if (tr_mosi[n] !== tr_mosi[n-1] && !(tr_sck[n-1] && !tr_sck[n])) cnt++;
      if (tr_mosi[n]) cnt2++;
      if (c1 < 0 && tr_sck[n-1] && !tr_sck[n]) c1 = n;
    end
    chk("m3_mosi_off_falling", cnt, 0);
    chk("m3_mosi_high", cnt2, 39);
    chk("m3_first_fall", c1, 3);
    chk("m3_rx_data", tr_rxd[35], 8'h3C);
    chk("m3_sck_idle_end", tr_sck[39], 1'b1);

    // LSB first, 0x01.
    setup(8'h01, 1'b0);
    run(2, 40);
    cnt = 0;
    for (int n = 1; n < 34; n++) if (tr_mosi[n]) cnt++;
    chk("lsb_mosi_ones", cnt, 4);
    chk("lsb_mosi_t4", tr_mosi[4], 1'b1);
    chk("lsb_mosi_t5", tr_mosi[5], 1'b0);
    chk("lsb_mosi_t34", tr_mosi[34], 1'b1);
    chk("lsb_rx_data", tr_rxd[35], 8'h01);

    // Held frame: 0x11 then 0x22 in HOLD, stray release mid-word, then release.
    setup(8'h11, 1'b1);
    off2 = 36; d2 = 8'h22; h2 = 1'b1; rel_a = 10; rel_b = 72;
    run(0, 80);
    cnt = 0; cnt2 = 0; c1 = -1; c2 = -1;
    for (int n = 1; n < 80; n++) begin
      if (n <= 74 && !tr_cs[n][0]) cnt++;
      if (tr_sck[n] && !tr_sck[n-1]) begin
        cnt2++;
        if (n > 36 && c2 < 0) c2 = n;
      end
      if (tr_rxv[n]) begin
        if (c1 < 0) c1 = n;
        else chk("hold_rxv2_cycle", n, 70);
      end
    end
    chk("hold_cs_low_span", cnt, 74);
    chk("hold_cs_t75", tr_cs[75][0], 1'b1);
    chk("hold_rise_count", cnt2, 16);
    chk("hold_second_first_rise", c2, 39);
    chk("hold_rxv1_cycle", c1, 34);
    chk("hold_rx1", tr_rxd[35], 8'h11);
    chk("hold_rx2", tr_rxd[71], 8'h22);
    chk("hold_mosi_idle", tr_mosi[35], 1'b1);
    chk("hold_ready", tr_rdy[35], 1'b1);
    chk("hold_sck_idle", tr_sck[35], 1'b0);

    // Three selects: index 2, then out-of-range index 3.
    setup(8'h5A, 1'b0);
    csg = 2'd2;
    run(3, 40);
    chk("cs2_t1", tr_cs[1], 3'b011);
    chk("cs2_t10", tr_cs[10], 3'b011);
    chk("cs2_t36", tr_cs[36], 3'b111);
    chk("cs2_rx_data", tr_rxd[35], 8'h5A);
    setup(8'hC3, 1'b0);
    csg = 2'd3;
    run(3, 40);
    cnt = 0; cnt2 = 0;
    for (int n = 0; n < 40; n++) begin
      if (tr_cs[n] != 3'b111) cnt++;
      if (tr_rxv[n]) cnt2++;
    end
    chk("cs3_no_select", cnt, 0);
    chk("cs3_rxv_count", cnt2, 1);
    chk("cs3_rx_data", tr_rxd[35], 8'hC3);

    // Reset at edge 9 of a word, then a cold word.
    setup(8'hA5, 1'b0);
    rst_on = 19; rst_off = 21;
    run(0, 40);
    chk("rst_pre_sck", tr_sck[19], 1'b1);
    chk("rst_snap_cs", sn_cs, 1'b1);
    chk("rst_snap_sck", sn_sck, 1'b0);
    chk("rst_snap_mosi", sn_mosi, 1'b1);
    chk("rst_snap_rxv", sn_rxv, 1'b0);
    chk("rst_snap_busy", sn_busy, 1'b0);
    chk("rst_snap_ready", sn_rdy, 1'b1);
    chk("rst_snap_rxd", sn_rxd, 8'h00);
    cnt = 0;
    for (int n = 0; n < 40; n++) if (tr_rxv[n]) cnt++;
    chk("rst_no_rxv", cnt, 0);
    setup(8'hA5, 1'b0);
    run(0, 40);
    chk_basic_a5();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
